empu_uart_rx: RTL and testbench
===============================

// Module: empu_uart_rx
// PURPOSE
//  Fabric-side UART receiver for the serial stream driven by the EMPU uart0_txd pin.
//  Deserialises 8N1 frames into bytes and buffers them in a show-ahead FIFO.
//  Fabric logic drains the FIFO over a valid/ready handshake.
//  Lets fabric consume Cortex-M3 console/command output without an external bridge.
// PARAMETERS
//  CLK_HZ      27000000  crystalClk frequency in Hz
//  BAUD        115200    line rate; CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD = 234 at defaults
//  FIFO_DEPTH  16        byte entries, power of 2, >= 2
// PORTS
//  crystalClk   in   1                    single system clock, all logic on rising edge
//  resetButton  in   1                    asynchronous active-low reset
//  rxSerial     in   1                    serial line from EMPU uart0_txd; async, idles high
//  rxData       out  8                    FIFO head byte; valid only while rxValid=1
//  rxValid      out  1                    FIFO not empty
//  rxReady      in   1                    consumer pops the head when rxValid && rxReady
//  fifoCount    out  $clog2(FIFO_DEPTH)+1 bytes currently held
//  frameError   out  1                    1-cycle pulse: stop bit sampled low, byte dropped
//  overflow     out  1                    1-cycle pulse: byte dropped because FIFO full
// BEHAVIOUR
//  Reset (async assert, sync release): 2-FF synchroniser regs=1, FSM=IDLE, FIFO empty.
//   Outputs at reset: rxValid=0, rxData=0, fifoCount=0, frameError=0, overflow=0.
//  Synchroniser: 2 flops on rxSerial; FSM uses only the synchronised bit (rxs).
//  Bit-timer counter reloads on every state change; bit counter is 0..7.
//  FSM:
//   IDLE  : rxs==0 -> START, timer = CLKS_PER_BIT/2 - 1 (116).
//   START : timer hits 0 -> rxs==0 ? DATA (timer = CLKS_PER_BIT-1, bit=0) : IDLE (glitch reject).
//   DATA  : timer hits 0 -> shift rxs in LSB-first; after bit 7 -> STOP; else reload timer.
//   STOP  : timer hits 0 -> rxs==1 : push byte, -> IDLE.
//           rxs==0 : frameError pulse, discard byte, -> BREAK.
//   BREAK : wait for rxs==1, then -> IDLE (no re-trigger during a held-low break).
//  Sampling is at mid-bit: start+0.5, then 1.5..8.5 bit times after the falling edge.
//   Synchroniser adds 2 cycles of constant offset.
//  Push occurs in the cycle after the stop-bit sample. rxValid rises the following cycle
//   (FIFO registered); a byte is visible 1 cycle after push.
//  FIFO: show-ahead; rxData reflects head combinationally from storage.
//   Pop when rxValid && rxReady; head advances next cycle.
//   Pointers wrap modulo FIFO_DEPTH; fifoCount = number held.
//  Full + push, no pop: byte dropped, overflow pulses 1 cycle, contents unchanged.
//  Full + push + pop same cycle: both performed, count stays FIFO_DEPTH, no overflow.
//  Empty + pop request: ignored (rxValid=0), count stays 0.
//  Push + pop, non-full: count unchanged.
//  frameError and overflow never assert together (different FSM exits).
//  Reset mid-frame: partial byte discarded, FIFO flushed, FSM to IDLE.
//   A frame in progress at reset release is re-acquired only on its next falling edge;
//   a 0-data bit may be taken as a start bit (receiver resyncs after one frame).
// TESTING
//  1 Send 0xA5 at 115200 (234 clk/bit) -> rxValid within 10 bit-times+3 clk, rxData=0xA5,
//    fifoCount=1; pop -> rxValid=0.
//  2 rxSerial low pulse of 100 clk then high -> no push, FSM back to IDLE,
//    frameError=0, fifoCount=0.
//  3 Frame 0x3C with stop bit held low 3 bit-times -> one frameError pulse, fifoCount=0;
//    next valid frame 0x11 received correctly.
//  4 rxReady=0, send 17 bytes 0x00..0x10 -> fifoCount=16, single overflow pulse on 17th;
//    drain yields 0x00..0x0F in order.
//  5 FIFO full, rxReady=1 held while next byte 0x77 completes -> no overflow,
//    0x77 is last byte drained.
//  6 Assert resetButton mid-bit 4 of a frame -> outputs at reset values within 1 clk;
//    next clean frame 0x5A after release received.

Source files
------------

// File: rtl/empu_uart_rx.sv
// Fabric-side 8N1 UART receiver for the EMPU console stream.
// Mid-bit sampling FSM feeding a show-ahead byte FIFO drained over valid/ready.
module empu_uart_rx #(
    parameter int CLK_HZ     = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        crystalClk,
    input  logic                        resetButton,
    input  logic                        rxSerial,
    output logic [7:0]                  rxData,
    output logic                        rxValid,
    input  logic                        rxReady,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic                        frameError,
    output logic                        overflow
);

    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [CW-1:0] COUNT_ONE   = CW'(1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          sync1_r;
    logic          rxs_r;
    logic [2:0]    state_r;
    logic [2:0]    state_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic          push_s;
    logic          ferr_s;
    logic          push_r;
    logic [7:0]    push_data_r;
    logic          timer_zero_s;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          valid_s;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          ovf_s;
    logic          frame_error_r;
    logic          overflow_r;

    // Two-flop synchroniser on the asynchronous serial line, idles high.
    always_ff @(posedge crystalClk or negedge resetButton) begin
        if (!resetButton) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rxSerial;
            rxs_r   <= sync1_r;
        end
    end

    assign timer_zero_s = (timer_r == TIMER_ZERO);

    // Receive FSM next-state logic; the bit timer reloads on every state change.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        push_s    = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rxs_r) begin
                    state_s = ST_START;
                    timer_s = HALF_RELOAD;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end
            ST_START: begin
                if (timer_zero_s) begin
                    if (!rxs_r) begin
                        state_s   = ST_DATA;
                        timer_s   = BIT_RELOAD;
                        bit_idx_s = 3'd0;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_s = ST_IDLE;
                        timer_s = TIMER_ZERO;
                    end
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_DATA: begin
                if (timer_zero_s) begin
                    shift_s = {rxs_r, shift_r[7:1]};
                    timer_s = BIT_RELOAD;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_STOP: begin
                if (timer_zero_s) begin
                    timer_s = TIMER_ZERO;
                    if (rxs_r) begin
                        push_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = ST_BREAK;
                    end
                end else begin
                    timer_s = timer_r - TIMER_ONE;
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a break never re-triggers.
                if (rxs_r) begin
                    state_s = ST_IDLE;
                    timer_s = TIMER_ZERO;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // Receive FSM state, timer, shift register and push/error strobes.
    always_ff @(posedge crystalClk or negedge resetButton) begin
        if (!resetButton) begin
            state_r       <= ST_IDLE;
            timer_r       <= TIMER_ZERO;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            push_r        <= 1'b0;
            push_data_r   <= 8'h00;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            bit_idx_r     <= bit_idx_s;
            shift_r       <= shift_s;
            push_r        <= push_s;
            push_data_r   <= shift_r;
            frame_error_r <= ferr_s;
        end
    end

    assign valid_s = (count_r != {CW{1'b0}});
    assign full_s  = (count_r == COUNT_FULL);
    assign pop_s   = valid_s && rxReady;
    assign wr_en_s = push_r && (!full_s || pop_s);
    assign ovf_s   = push_r && full_s && !pop_s;

    // Byte storage; contents are don't-care outside the occupied window.
    always_ff @(posedge crystalClk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and overflow strobe.
    always_ff @(posedge crystalClk or negedge resetButton) begin
        if (!resetButton) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= ovf_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign rxValid    = valid_s;
    assign rxData     = valid_s ? mem_r[rd_ptr_r] : 8'h00;
    assign fifoCount  = count_r;
    assign frameError = frame_error_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_empu_uart_rx.sv
// Self-checking bench for empu_uart_rx: table-driven frames, directed corner
// sequences and random traffic checked against a byte-queue reference model.
module tb_empu_uart_rx;

    localparam int CLK_HZ = 27000000;
    localparam int BAUD   = 1000000;
    localparam int DEPTH  = 16;
    localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF   = CPB / 2;
    // Frame-relative cycle (start edge = 0) whose next rising edge commits a good byte:
    // 2 synchroniser flops + 1 detect, half a bit, nine more bits to the stop sample.
    localparam int PUSH_IDX = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_error;
    logic       overflow;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         ferr_cnt = 0;
    int         ovf_cnt = 0;
    int         exp_ferr = 0;
    int         exp_ovf = 0;
    int         valid_seen_idx;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         exp_count;
        int         exp_ferr_inc;
    } vec_t;
    vec_t vecs[6];

    empu_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .crystalClk (clk),
        .resetButton(rst_n),
        .rxSerial   (rx_line),
        .rxData     (rx_data),
        .rxValid    (rx_valid),
        .rxReady    (rdy),
        .fifoCount  (fifo_count),
        .frameError (frame_error),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts strobes and checks every popped byte against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (frame_error) ferr_cnt++;
            if (overflow) ovf_cnt++;
            if (rx_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Model of a byte completing: kept unless the queue is full with no pop this cycle.
    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() == DEPTH && !rdy) exp_ovf++;
        else exp_q.push_back(d);
    endtask

    // rdy_mode: 0 hold, 1 random per cycle, 2 one-cycle pulse at evt_idx, 3 reset from evt_idx
    task automatic send_frame(input logic [7:0] data, input int stop_low,
                              input int rdy_mode, input int evt_idx);
        int nbits;
        int total;
        int b;
        nbits = (stop_low == 0) ? 10 : 10 + stop_low;
        total = (nbits + 1) * CPB;
        valid_seen_idx = -1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            b = k / CPB;
            if (b == 0) rx_line = 1'b0;
            else if (b <= 8) rx_line = data[b-1];
            else if (b < 9 + stop_low) rx_line = 1'b0;
            else rx_line = 1'b1;
            if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
            else if (rdy_mode == 2) rdy = (k == evt_idx);
            if (rdy_mode == 3 && k == evt_idx) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
                check("rst_mid_data", {24'd0, rx_data}, 32'd0);
                check("rst_mid_count", {27'd0, fifo_count}, 32'd0);
                check("rst_mid_ferr", {31'd0, frame_error}, 32'd0);
                check("rst_mid_ovf", {31'd0, overflow}, 32'd0);
                exp_q.delete();
            end
            if (k == PUSH_IDX && stop_low == 0 && rst_n) model_push(data);
            if (valid_seen_idx < 0 && rx_valid) valid_seen_idx = k;
        end
        if (stop_low != 0 && rst_n) exp_ferr++;
        if (rdy_mode == 1 || rdy_mode == 2) rdy = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        #2;
        check($sformatf("%s_count", tag), {27'd0, fifo_count}, exp_q.size());
        check($sformatf("%s_ferr", tag), ferr_cnt, exp_ferr);
        check($sformatf("%s_ovf", tag), ovf_cnt, exp_ovf);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
            @(negedge clk);
            rdy = 1'b1;
            guard++;
        end
        @(negedge clk);
        rdy = 1'b0;
        check($sformatf("%s_drained", tag), exp_q.size(), 0);
        check_counts(tag);
        check($sformatf("%s_valid_low", tag), {31'd0, rx_valid}, 32'd0);
    endtask

    initial begin
        int ferr_before;
        int ovf_before;
        vecs[0] = '{8'h55, 0, 1, 0};
        vecs[1] = '{8'h00, 0, 2, 0};
        vecs[2] = '{8'hFF, 0, 3, 0};
        vecs[3] = '{8'h81, 1, 3, 1};
        vecs[4] = '{8'h3C, 3, 3, 1};
        vecs[5] = '{8'h11, 0, 4, 0};

        repeat (3) @(negedge clk);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'd0);
        check("reset_count", {27'd0, fifo_count}, 32'd0);
        check("reset_ferr", {31'd0, frame_error}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte, latency bound and show-ahead head value.
        rdy = 1'b0;
        send_frame(8'hA5, 0, 0, 0);
        check("t1_latency", (valid_seen_idx > 9 * CPB && valid_seen_idx <= 10 * CPB + 3), 1);
        check("t1_data", {24'd0, rx_data}, 32'hA5);
        check_counts("t1");
        drain("t1");

        // Short low glitch must be rejected.
        @(negedge clk);
        rx_line = 1'b0;
        repeat (CPB * 100 / 234) @(negedge clk);
        rx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_counts("t2");

        // Table of frames with good and bad stop bits, consumer stalled.
        for (int i = 0; i < 6; i++) begin
            ferr_before = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_low, 0, 0);
            @(negedge clk);
            #2;
            check($sformatf("vec%0d_count", i), {27'd0, fifo_count}, vecs[i].exp_count);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - ferr_before, vecs[i].exp_ferr_inc);
        end
        drain("vec");

        // Seventeen bytes into a sixteen-deep FIFO with no consumer.
        ovf_before = ovf_cnt;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, 0, 0);
        @(negedge clk);
        #2;
        check("t4_full", {27'd0, fifo_count}, 32'd16);
        check("t4_ovf_once", ovf_cnt - ovf_before, 1);
        drain("t4");

        // Full FIFO, pop coincides with the push cycle of 0x77.
        for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 0, 0, 0);
        ovf_before = ovf_cnt;
        send_frame(8'h77, 0, 2, PUSH_IDX);
        @(negedge clk);
        #2;
        check("t5_no_ovf", ovf_cnt - ovf_before, 0);
        check("t5_full", {27'd0, fifo_count}, 32'd16);
        check("t5_tail", {24'd0, exp_q[exp_q.size()-1]}, 32'h77);
        drain("t5");

        // Full FIFO with the consumer ready throughout the next frame.
        for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 0, 0, 0);
        rdy = 1'b1;
        send_frame(8'h77, 0, 0, 0);
        rdy = 1'b0;
        check_counts("t5b");
        drain("t5b");

        // Reset in the middle of data bit 4 with a byte already buffered.
        send_frame(8'hC3, 0, 0, 0);
        check_counts("t6_pre");
        send_frame(8'h96, 0, 3, 5 * CPB + HALF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_counts("t6_post");
        send_frame(8'h5A, 0, 0, 0);
        check("t6_data", {24'd0, rx_data}, 32'h5A);
        check_counts("t6");
        drain("t6");

        // Random bytes, random stop errors, randomly stalling consumer.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            int sl;
            d = 8'($urandom_range(0, 255));
            sl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_frame(d, sl, 1, 0);
            check_counts($sformatf("rnd%0d", i));
        end
        drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
